// File: rtl/lc2k_mem_requester.sv
`default_nettype none
// ============================================================================
// Module   : lc2k_mem_requester
// Purpose  : MEM-stage initiator for the LC2K pipeline. Issues one load/store
//            at a time on a valid/ready request channel, waits for the memory
//            response, stalls upstream stages meanwhile and returns load data.
// Options  : LC2K_MEM_TIMEOUT_EN - bounds the response wait to TIMEOUT_CYCLES
//            and raises a sticky mem_error on expiry.
// Revision : 1.0 - initial release
// ============================================================================
module lc2k_mem_requester #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_valid,
   input  logic              CONTROL_MEM_ACCESS,
   input  logic              CONTROL_ENABLE_MEM_WRITE,
   input  logic [DATA_W-1:0] aluResult,
   input  logic [DATA_W-1:0] regBvalue,
   output logic              stall,
   output logic              result_valid,
   output logic [DATA_W-1:0] memResult,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic              dmem_req_write,
   output logic [ADDR_W-1:0] dmem_req_addr,
   output logic [DATA_W-1:0] dmem_req_wdata,
   input  logic              dmem_rsp_valid,
   input  logic [DATA_W-1:0] dmem_rsp_rdata,
   output logic              mem_error
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_REQ      = 2'd1,
      S_WAIT_RSP = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_write;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_mem_result;
   logic                w_start;
   logic                w_timeout;

   assign w_start = mem_valid & CONTROL_MEM_ACCESS;

   // Address bits above ADDR_W are intentionally discarded.
   generate
      if (DATA_W > ADDR_W) begin : g_addr_trunc
         logic w_unused_addr_hi;
         assign w_unused_addr_hi = ^aluResult[DATA_W-1:ADDR_W];
      end
   endgenerate

`ifdef LC2K_MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] r_count;
   logic             r_mem_error;

   // Count response-wait cycles; restarts while the request is being offered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (r_state == S_REQ) begin
         r_count <= '0;
      end else if (r_state == S_WAIT_RSP) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   // A response arriving in the expiry cycle takes priority over the timeout.
   assign w_timeout = (r_state == S_WAIT_RSP) & ~dmem_rsp_valid &
                      (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_error <= 1'b0;
      end else if (w_timeout) begin
         r_mem_error <= 1'b1;
      end
   end

   assign mem_error = r_mem_error;
`else
   assign w_timeout = 1'b0;
   assign mem_error = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and handshake outputs; stall is forced low while in reset.
   always_comb begin
      w_state_next   = r_state;
      stall          = 1'b0;
      dmem_req_valid = 1'b0;
      result_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_next = S_REQ;
               stall        = ~reset;
            end
         end
         S_REQ: begin
            stall          = 1'b1;
            dmem_req_valid = 1'b1;
            if (dmem_req_ready) begin
               w_state_next = S_WAIT_RSP;
            end
         end
         S_WAIT_RSP: begin
            stall = 1'b1;
            if (dmem_rsp_valid || w_timeout) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            result_valid = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Capture the request in IDLE only, so it stays stable while offered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if ((r_state == S_IDLE) && w_start) begin
         r_write <= CONTROL_ENABLE_MEM_WRITE;
         r_addr  <= aluResult[ADDR_W-1:0];
         r_wdata <= regBvalue;
      end
   end

   // Load data updates on a load response (or zero on load timeout); stores keep it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_result <= '0;
      end else if ((r_state == S_WAIT_RSP) && !r_write) begin
         if (dmem_rsp_valid) begin
            r_mem_result <= dmem_rsp_rdata;
         end else if (w_timeout) begin
            r_mem_result <= '0;
         end
      end
   end

   assign memResult      = r_mem_result;
   assign dmem_req_write = r_write;
   assign dmem_req_addr  = r_addr;
   assign dmem_req_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lc2k_mem_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc2k_mem_requester
// Purpose  : Self-checking bench for lc2k_mem_requester: directed scenarios
//            with literal expectations plus a transaction-level reference
//            model compared against the DUT on every falling clock edge.
//            Define LC2K_MEM_TIMEOUT_EN to include the timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc2k_mem_requester;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 16;
   localparam int TO     = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              mem_valid = 1'b0;
   logic              acc = 1'b0;
   logic              wr = 1'b0;
   logic [DATA_W-1:0] alu = '0;
   logic [DATA_W-1:0] regb = '0;
   logic              stall;
   logic              result_valid;
   logic [DATA_W-1:0] mem_result;
   logic              req_valid;
   logic              rdy = 1'b0;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rspv = 1'b0;
   logic [DATA_W-1:0] rdata = '0;
   logic              mem_error;

   int checks = 0;
   int errors = 0;

   lc2k_mem_requester #(
      .DATA_W         (DATA_W),
      .ADDR_W         (ADDR_W),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                      (clk),
      .reset                    (reset),
      .mem_valid                (mem_valid),
      .CONTROL_MEM_ACCESS       (acc),
      .CONTROL_ENABLE_MEM_WRITE (wr),
      .aluResult                (alu),
      .regBvalue                (regb),
      .stall                    (stall),
      .result_valid             (result_valid),
      .memResult                (mem_result),
      .dmem_req_valid           (req_valid),
      .dmem_req_ready           (rdy),
      .dmem_req_write           (req_write),
      .dmem_req_addr            (req_addr),
      .dmem_req_wdata           (req_wdata),
      .dmem_rsp_valid           (rspv),
      .dmem_rsp_rdata           (rdata),
      .mem_error                (mem_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Transaction-level reference model: one access in flight at most.
   // m_busy   : access accepted from the pipeline, not yet answered
   // m_issued : memory has taken the request, waiting for its answer
   // m_done   : completion pulse cycle
   // ---------------------------------------------------------------------
   logic              m_busy = 1'b0;
   logic              m_issued = 1'b0;
   logic              m_done = 1'b0;
   logic              m_write = 1'b0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [DATA_W-1:0] m_wdata = '0;
   logic [DATA_W-1:0] m_result = '0;
   logic              m_error = 1'b0;
   int                m_wait = 0;
   logic              e_stall;
   logic              e_reqv;

   always @(negedge clk) begin
      if (reset) begin
         chk("m_rst_stall", stall, 0);
         chk("m_rst_rv", result_valid, 0);
         chk("m_rst_reqv", req_valid, 0);
         chk("m_rst_write", req_write, 0);
         chk("m_rst_addr", req_addr, 0);
         chk("m_rst_wdata", req_wdata, 0);
         chk("m_rst_memresult", mem_result, 0);
         chk("m_rst_err", mem_error, 0);
         m_busy   = 1'b0;
         m_issued = 1'b0;
         m_done   = 1'b0;
         m_result = '0;
         m_error  = 1'b0;
         m_wait   = 0;
      end else begin
         e_stall = m_busy || (!m_done && mem_valid && acc);
         e_reqv  = m_busy && !m_issued;
         chk("m_stall", stall, e_stall);
         chk("m_result_valid", result_valid, m_done);
         chk("m_req_valid", req_valid, e_reqv);
         chk("m_memResult", mem_result, m_result);
         chk("m_mem_error", mem_error, m_error);
         if (e_reqv) begin
            chk("m_req_write", req_write, m_write);
            chk("m_req_addr", req_addr, m_addr);
            chk("m_req_wdata", req_wdata, m_wdata);
         end
         // advance the model with the inputs seen by the coming rising edge
         if (m_done) begin
            m_done = 1'b0;
         end else if (!m_busy) begin
            if (mem_valid && acc) begin
               m_busy   = 1'b1;
               m_issued = 1'b0;
               m_write  = wr;
               m_addr   = alu[ADDR_W-1:0];
               m_wdata  = regb;
            end
         end else if (!m_issued) begin
            if (rdy) begin
               m_issued = 1'b1;
               m_wait   = 0;
            end
         end else if (rspv) begin
            if (!m_write) m_result = rdata;
            m_busy = 1'b0;
            m_done = 1'b1;
         end else begin
`ifdef LC2K_MEM_TIMEOUT_EN
            m_wait = m_wait + 1;
            if (m_wait == TO) begin
               if (!m_write) m_result = '0;
               m_error = 1'b1;
               m_busy  = 1'b0;
               m_done  = 1'b1;
            end
`endif
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int nreq;
   int npulse;
   int kdone;

   // Directed scenarios with hand-computed expectations.
   initial begin
      #1 reset = 1'b1;
      step();
      chk("rst_memResult", mem_result, 0);
      chk("rst_reqv", req_valid, 0);
      reset = 1'b0;

      // 1: load, immediate ready and response
      step();
      mem_valid = 1; acc = 1; wr = 0; alu = 5; regb = 0; rdy = 1; rspv = 1; rdata = 32'h1234;
      #1;
      chk("t1_c0_stall", stall, 1);
      chk("t1_c0_reqv", req_valid, 0);
      step(); mem_valid = 0; #1;
      chk("t1_c1_stall", stall, 1);
      chk("t1_c1_reqv", req_valid, 1);
      chk("t1_c1_addr", req_addr, 5);
      chk("t1_c1_write", req_write, 0);
      step(); #1;
      chk("t1_c2_stall", stall, 1);
      chk("t1_c2_reqv", req_valid, 0);
      chk("t1_c2_rv", result_valid, 0);
      step(); #1;
      chk("t1_c3_stall", stall, 0);
      chk("t1_c3_rv", result_valid, 1);
      chk("t1_c3_memResult", mem_result, 32'h1234);
      step(); #1;
      chk("t1_c4_rv", result_valid, 0);

      // 2: store, ready delayed 4 cycles
      step();
      mem_valid = 1; acc = 1; wr = 1; alu = 9; regb = 32'hBEEF; rdy = 0; rspv = 0; rdata = 32'hDEAD;
      #1;
      chk("t2_c0_stall", stall, 1);
      nreq = 0; npulse = 0;
      for (int k = 1; k <= 9; k++) begin
         step();
         mem_valid = 0; alu = 32'h33; regb = 32'h44;
         rdy = (k == 5); rspv = (k >= 6);
         #1;
         if (req_valid) begin
            nreq++;
            chk("t2_addr", req_addr, 9);
            chk("t2_wdata", req_wdata, 32'hBEEF);
            chk("t2_write", req_write, 1);
         end
         if (result_valid) npulse++;
      end
      chk("t2_req_cycles", nreq, 5);
      chk("t2_pulses", npulse, 1);
      chk("t2_memResult", mem_result, 32'h1234);

      // 3: back-to-back lw then sw, address changed mid-access
      step();
      mem_valid = 1; acc = 1; wr = 0; alu = 7; regb = 0; rdy = 1; rspv = 1; rdata = 32'h55;
      #1;
      chk("t3_c0_stall", stall, 1);
      step(); alu = 100; wr = 1; regb = 32'h77; #1;
      chk("t3_c1_reqv", req_valid, 1);
      chk("t3_c1_addr", req_addr, 7);
      chk("t3_c1_write", req_write, 0);
      step(); #1;
      chk("t3_c2_reqv", req_valid, 0);
      step(); #1;
      chk("t3_c3_rv", result_valid, 1);
      chk("t3_c3_stall", stall, 0);
      chk("t3_c3_reqv", req_valid, 0);
      chk("t3_c3_memResult", mem_result, 32'h55);
      step(); #1;
      chk("t3_c4_stall", stall, 1);
      chk("t3_c4_reqv", req_valid, 0);
      chk("t3_c4_rv", result_valid, 0);
      step(); mem_valid = 0; #1;
      chk("t3_c5_reqv", req_valid, 1);
      chk("t3_c5_addr", req_addr, 100);
      chk("t3_c5_write", req_write, 1);
      chk("t3_c5_wdata", req_wdata, 32'h77);
      step(); step(); #1;
      chk("t3_c7_rv", result_valid, 1);
      chk("t3_c7_memResult", mem_result, 32'h55);
      step();

      // 4: reset while waiting for the response, then a late response
      step();
      mem_valid = 1; acc = 1; wr = 0; alu = 2; rdy = 1; rspv = 0;
      #1;
      step(); mem_valid = 0; #1;
      step(); #1;
      chk("t4_wait_stall", stall, 1);
      #1 reset = 1'b1;
      #1;
      chk("t4_rst_stall", stall, 0);
      chk("t4_rst_rv", result_valid, 0);
      chk("t4_rst_reqv", req_valid, 0);
      chk("t4_rst_addr", req_addr, 0);
      chk("t4_rst_memResult", mem_result, 0);
      step();
      rspv = 1; rdata = 32'h99; reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(); #1;
         chk("t4_late_rv", result_valid, 0);
         chk("t4_late_stall", stall, 0);
         chk("t4_late_memResult", mem_result, 0);
      end

      // 5: spurious response in IDLE, non-memory instruction, address truncation
      step(); rspv = 1; rdata = 32'hFFFF; mem_valid = 1; acc = 0; #1;
      for (int k = 0; k < 2; k++) begin
         chk("t5_idle_stall", stall, 0);
         chk("t5_idle_rv", result_valid, 0);
         chk("t5_idle_reqv", req_valid, 0);
         step(); #1;
      end
      mem_valid = 1; acc = 1; wr = 0; alu = 32'h0001_0003; rdy = 1; rspv = 1; rdata = 32'hA5;
      #1;
      step(); mem_valid = 0; #1;
      chk("t5_reqv", req_valid, 1);
      chk("t5_addr", req_addr, 3);
      step(); step(); #1;
      chk("t5_rv", result_valid, 1);
      chk("t5_memResult", mem_result, 32'hA5);
      chk("t5_err", mem_error, 0);
      step();

`ifdef LC2K_MEM_TIMEOUT_EN
      // 6: no response ever arrives
      step();
      mem_valid = 1; acc = 1; wr = 0; alu = 4; rdy = 1; rspv = 0;
      #1;
      kdone = 31;
      for (int k = 1; k <= 30; k++) begin
         step(); mem_valid = 0; #1;
         if (result_valid && kdone == 31) kdone = k;
      end
      chk("t6_done_cycle", kdone, 10);
      chk("t6_memResult", mem_result, 0);
      chk("t6_err", mem_error, 1);
      #1 reset = 1'b1;
      #1;
      chk("t6_err_rst", mem_error, 0);
      step(); reset = 1'b0;
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/lc2k_mem_requester.md
Name: lc2k_mem_requester

Overview:
- MEM-stage initiator for the LC2K pipeline: the requesting side of the data-memory interface.
- Takes the pipeline's load/store request (ALU address, regB store data, access/write controls) and drives a valid/ready request channel to the data memory. It then waits for the memory's response, so memory latency is no longer assumed to be zero.
- Stalls the pipeline while a request is outstanding and returns the load result (memResult) to writeback.

Parameters:
- DATA_W, 32, word width of load/store data.
- ADDR_W, 16, word-address width sent to memory; aluResult is truncated to its low ADDR_W bits.
- TIMEOUT_CYCLES, 64, WAIT_RSP cycles allowed before a timeout (optional feature only).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_valid  in  1  MEM stage holds a valid instruction.
- CONTROL_MEM_ACCESS  in  1  1 = instruction is lw/sw.
- CONTROL_ENABLE_MEM_WRITE  in  1  1 = store, 0 = load.
- aluResult  in  DATA_W  effective address.
- regBvalue  in  DATA_W  store data.
- stall  out  1  freeze pipeline stages upstream of MEM.
- result_valid  out  1  one-cycle pulse: access complete.
- memResult  out  DATA_W  load data, held until the next load completes.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_req_write  out  1  1 = write.
- dmem_req_addr  out  ADDR_W  word address.
- dmem_req_wdata  out  DATA_W  write data.
- dmem_rsp_valid  in  1  response/ack valid.
- dmem_rsp_rdata  in  DATA_W  read data (ignored for writes).
- mem_error  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, stall=0, result_valid=0, memResult=0, dmem_req_valid=0, dmem_req_write=0, dmem_req_addr=0, dmem_req_wdata=0, mem_error=0. Any in-flight access is abandoned; a late response arriving after reset is ignored.
- States and transitions:
  - IDLE: start = mem_valid & CONTROL_MEM_ACCESS. On start, latch write flag, aluResult[ADDR_W-1:0] and regBvalue; next state REQ. stall is asserted combinationally in the start cycle. Without start, stay in IDLE with stall=0.
  - REQ: dmem_req_valid=1. Valid, write, addr and wdata stay stable until dmem_req_ready=1 (no retraction). On ready, go to WAIT_RSP next cycle.
  - WAIT_RSP: dmem_req_valid=0. On dmem_rsp_valid: for a load, memResult<=dmem_rsp_rdata; for a store, the response is the write ack and memResult is unchanged. Next state DONE.
  - DONE: result_valid=1 and stall=0 for exactly one cycle, then IDLE.
- stall = (IDLE & start) | REQ | WAIT_RSP.
- Upstream must advance in the DONE cycle. A back-to-back access is taken in the following IDLE cycle, so accesses are separated by at least one bubble.
- Minimum latency with ready and response both immediate: start in cycle 0, REQ/ready in cycle 1, WAIT_RSP/rsp in cycle 2, DONE in cycle 3 (3 stall cycles).
- Inputs are sampled only in IDLE; changes during REQ, WAIT_RSP or DONE are ignored.
- dmem_rsp_valid in IDLE, REQ or DONE is spurious and ignored.
- Upper address bits above ADDR_W are silently dropped.
- Only one request is ever outstanding.

Optional Feature:
- LC2K_MEM_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_RSP and increments each WAIT_RSP cycle.
  - When it reaches TIMEOUT_CYCLES without a response: go to DONE, memResult<=0 for a load, and set mem_error.
  - mem_error stays set until reset.
  - A response in the same cycle as the timeout wins: normal completion, no error.
- Not defined: WAIT_RSP waits indefinitely, no counter logic exists, and mem_error is tied to 0.

Test Plan:
- Load, immediate ready and response: aluResult=5, rdata=0x1234 → req_addr=5, req_write=0; stall high cycles 0–2; result_valid in cycle 3; memResult=0x1234.
- Store with ready delayed 4 cycles: regBvalue=0xBEEF, aluResult=9 → req_valid held 5 cycles with addr=9 and wdata=0xBEEF stable throughout; memResult unchanged; one result_valid pulse.
- Back-to-back lw then sw, with aluResult changed mid-access → the first request uses the latched address; second request issues only after the DONE→IDLE bubble.
- Reset asserted in WAIT_RSP, then rsp_valid arrives → all outputs 0 immediately; no result_valid; late response ignored.
- Spurious rsp_valid in IDLE, and aluResult=0x0001_0003 → no state change; later request drives req_addr=3.
- LC2K_MEM_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no response → DONE after 8 WAIT_RSP cycles, memResult=0, mem_error=1 until reset.
